// File: rtl/key_pkg.sv
// Shared types and helpers for the KEY debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    WAIT_DN = 2'd1,
    DOWN    = 2'd2,
    WAIT_UP = 2'd3
  } key_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchroniser, debounce FSM, press/release strobes.
// Optional long-press detector is built only when KEY_LONG_PRESS_EN is defined.
//
//   state   | meaning
//   UP      | key released and stable
//   WAIT_DN | key seen low, qualifying the press
//   DOWN    | key pressed and stable
//   WAIT_UP | key seen high, qualifying the release
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
`ifdef KEY_LONG_PRESS_EN
  , parameter int unsigned LONG_CYCLES = 20
`endif
) (
  input  logic clk_sys_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic long_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             held;

  // Reset to released so that reset release never looks like a press
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign key_s = sync_q[1];

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= UP;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Counter defaults to zero so every state exit clears it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      UP: begin
        if (!key_s) begin
          state_d = WAIT_DN;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_DN: begin
        if (key_s) begin
          state_d = UP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = WAIT_UP;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_UP: begin
        if (!key_s) begin
          state_d = DOWN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = UP;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = UP;
    endcase
  end

  assign held    = (state_q == DOWN) || (state_q == WAIT_UP);
  assign level_o = ~held;
  assign press_o = press_q;
  assign rel_o   = rel_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Saturating at HOLD_MAX limits the strobe to one per press
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == UP) begin
      hold_d = '0;
    end else if (held && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_PRE);
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces the active-low KEY pushbuttons: clean level plus press/release strobes per key.
// KEY_LONG strobes on a long hold only when KEY_LONG_PRESS_EN is defined; otherwise it is 0.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_REL,
  output logic [NUM_KEYS-1:0] KEY_LONG
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
`endif

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES)
`ifdef KEY_LONG_PRESS_EN
      , .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .clk_sys_i (CLOCK_50),
      .rst_n_i   (RESET_N),
      .key_i     (KEY[k]),
      .level_o   (KEY_LEVEL[k]),
      .press_o   (KEY_PRESS[k]),
      .rel_o     (KEY_REL[k]),
      .long_o    (KEY_LONG[k])
    );
  end

endmodule
